// File: rtl/cu_xb_wb_if.sv
// Write-back crossbar bus: result sources, issue reservations,
// register-file write port and scoreboard view.
interface cu_xb_wb_if #(
   parameter int DATA_WIDTH    = 16,
   parameter int ADDRESS_WIDTH = 4
);
   logic                        alu_xb_vld;
   logic [ADDRESS_WIDTH-1:0]    alu_xb_wrtA;
   logic [DATA_WIDTH-1:0]       alu_xb_d;
   logic                        mul_xb_vld;
   logic [ADDRESS_WIDTH-1:0]    mul_xb_wrtA;
   logic [DATA_WIDTH-1:0]       mul_xb_d;
   logic                        xb_mul_rdy;
   logic                        dm_xb_vld;
   logic [ADDRESS_WIDTH-1:0]    dm_xb_wrtA;
   logic [DATA_WIDTH-1:0]       dm_xb_d;
   logic                        xb_dm_rdy;
   logic                        ps_xb_issue;
   logic [ADDRESS_WIDTH-1:0]    ps_xb_issueA;
   logic                        xb_rf_En;
   logic [ADDRESS_WIDTH-1:0]    xb_rf_wrtA;
   logic [DATA_WIDTH-1:0]       xb_rf_d;
   logic [2**ADDRESS_WIDTH-1:0] xb_ps_busy;
   logic                        xb_ps_err;

   modport master (
      output alu_xb_vld, alu_xb_wrtA, alu_xb_d,
      output mul_xb_vld, mul_xb_wrtA, mul_xb_d,
      output dm_xb_vld, dm_xb_wrtA, dm_xb_d,
      output ps_xb_issue, ps_xb_issueA,
      input  xb_mul_rdy, xb_dm_rdy,
      input  xb_rf_En, xb_rf_wrtA, xb_rf_d,
      input  xb_ps_busy, xb_ps_err
   );

   modport slave (
      input  alu_xb_vld, alu_xb_wrtA, alu_xb_d,
      input  mul_xb_vld, mul_xb_wrtA, mul_xb_d,
      input  dm_xb_vld, dm_xb_wrtA, dm_xb_d,
      input  ps_xb_issue, ps_xb_issueA,
      output xb_mul_rdy, xb_dm_rdy,
      output xb_rf_En, xb_rf_wrtA, xb_rf_d,
      output xb_ps_busy, xb_ps_err
   );
endinterface

// File: rtl/cu_xb_wb.sv
// Compute-unit write-back arbiter: ALU/MUL/DM onto one register-file
// write port, with a pending-destination scoreboard for the sequencer.
module cu_xb_wb #(
   parameter int DATA_WIDTH    = 16,
   parameter int ADDRESS_WIDTH = 4
) (
   input logic         clk,
   input logic         rst_n,
   cu_xb_wb_if.slave   xb
);
   localparam int NREG = 2**ADDRESS_WIDTH;
   localparam logic [NREG-1:0] ONE = {{(NREG-1){1'b0}}, 1'b1};

   typedef enum logic {RR_MUL, RR_DM} rr_e;

   logic                     mul_v_q, mul_v_d;
   logic [ADDRESS_WIDTH-1:0] mul_a_q, mul_a_d;
   logic [DATA_WIDTH-1:0]    mul_dat_q, mul_dat_d;
   logic                     dm_v_q, dm_v_d;
   logic [ADDRESS_WIDTH-1:0] dm_a_q, dm_a_d;
   logic [DATA_WIDTH-1:0]    dm_dat_q, dm_dat_d;
   rr_e                      rr_q, rr_d;
   logic                     rf_en_q, rf_en_d;
   logic [ADDRESS_WIDTH-1:0] rf_a_q, rf_a_d;
   logic [DATA_WIDTH-1:0]    rf_dat_q, rf_dat_d;
   logic [NREG-1:0]          busy_q, busy_d;
   logic                     err_q, err_d;
   logic                     gnt_mul, gnt_dm;
   logic [NREG-1:0]          set_vec, clr_vec;

   always_comb begin
      gnt_mul = 1'b0;
      gnt_dm  = 1'b0;
      rr_d    = rr_q;
      if (!xb.alu_xb_vld) begin
         if (mul_v_q && dm_v_q) begin
            gnt_mul = (rr_q == RR_MUL);
            gnt_dm  = (rr_q == RR_DM);
            rr_d    = (rr_q == RR_MUL) ? RR_DM : RR_MUL;
         end else begin
            gnt_mul = mul_v_q;
            gnt_dm  = dm_v_q;
         end
      end
   end

   always_comb begin
      rf_en_d  = 1'b1;
      rf_a_d   = rf_a_q;
      rf_dat_d = rf_dat_q;
      unique case (1'b1)
         xb.alu_xb_vld: begin
            rf_a_d   = xb.alu_xb_wrtA;
            rf_dat_d = xb.alu_xb_d;
         end
         gnt_mul: begin
            rf_a_d   = mul_a_q;
            rf_dat_d = mul_dat_q;
         end
         gnt_dm: begin
            rf_a_d   = dm_a_q;
            rf_dat_d = dm_dat_q;
         end
         default: rf_en_d = 1'b0;
      endcase
   end

   // An entry granted this cycle stays non-ready until the edge frees it.
   always_comb begin
      mul_v_d   = mul_v_q & ~gnt_mul;
      mul_a_d   = mul_a_q;
      mul_dat_d = mul_dat_q;
      dm_v_d    = dm_v_q & ~gnt_dm;
      dm_a_d    = dm_a_q;
      dm_dat_d  = dm_dat_q;
      if (xb.mul_xb_vld && !mul_v_q) begin
         mul_v_d   = 1'b1;
         mul_a_d   = xb.mul_xb_wrtA;
         mul_dat_d = xb.mul_xb_d;
      end
      if (xb.dm_xb_vld && !dm_v_q) begin
         dm_v_d   = 1'b1;
         dm_a_d   = xb.dm_xb_wrtA;
         dm_dat_d = xb.dm_xb_d;
      end
   end

   // Reservation beats retirement on the same bit.
   always_comb begin
      set_vec = xb.ps_xb_issue ? (ONE << xb.ps_xb_issueA) : '0;
      clr_vec = rf_en_q ? (ONE << rf_a_q) : '0;
      busy_d  = (busy_q & ~clr_vec) | set_vec;
      err_d   = err_q |
                (rf_en_q & ~busy_q[rf_a_q] & ~set_vec[rf_a_q]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mul_v_q   <= 1'b0;
         mul_a_q   <= '0;
         mul_dat_q <= '0;
         dm_v_q    <= 1'b0;
         dm_a_q    <= '0;
         dm_dat_q  <= '0;
         rr_q      <= RR_MUL;
         rf_en_q   <= 1'b0;
         rf_a_q    <= '0;
         rf_dat_q  <= '0;
         busy_q    <= '0;
         err_q     <= 1'b0;
      end else begin
         mul_v_q   <= mul_v_d;
         mul_a_q   <= mul_a_d;
         mul_dat_q <= mul_dat_d;
         dm_v_q    <= dm_v_d;
         dm_a_q    <= dm_a_d;
         dm_dat_q  <= dm_dat_d;
         rr_q      <= rr_d;
         rf_en_q   <= rf_en_d;
         rf_a_q    <= rf_a_d;
         rf_dat_q  <= rf_dat_d;
         busy_q    <= busy_d;
         err_q     <= err_d;
      end
   end

   assign xb.xb_mul_rdy = ~mul_v_q;
   assign xb.xb_dm_rdy  = ~dm_v_q;
   assign xb.xb_rf_En   = rf_en_q;
   assign xb.xb_rf_wrtA = rf_a_q;
   assign xb.xb_rf_d    = rf_dat_q;
   assign xb.xb_ps_busy = busy_q;
   assign xb.xb_ps_err  = err_q;
endmodule

// File: tb/tb_cu_xb_wb.sv
// Bench for cu_xb_wb: directed scenarios plus random traffic
// checked against a transaction-level model of the write-back path.
module tb_cu_xb_wb;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   cu_xb_wb_if #(.DATA_WIDTH(16), .ADDRESS_WIDTH(4)) bus ();

   cu_xb_wb #(.DATA_WIDTH(16), .ADDRESS_WIDTH(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .xb    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // stimulus intent
   bit         a_vld, iss, mul_pend, dm_pend;
   logic [3:0] a_a, iss_a, mul_a, dm_a;
   logic [15:0] a_d, mul_d, dm_d;

   // reference model
   bit          m_en, m_err, m_mv, m_dv, m_rr_dm;
   logic [3:0]  m_a, hm_a, hd_a;
   logic [15:0] m_d, hm_d, hd_d;
   bit          m_busy [16];

   logic [3:0] order [$];

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] busy_vec();
      logic [15:0] v;
      for (int i = 0; i < 16; i++) v[i] = m_busy[i];
      return v;
   endfunction

   task automatic model_clear();
      m_en = 0; m_err = 0; m_mv = 0; m_dv = 0; m_rr_dm = 0;
      m_a = 0; m_d = 0; hm_a = 0; hm_d = 0; hd_a = 0; hd_d = 0;
      for (int i = 0; i < 16; i++) m_busy[i] = 0;
      a_vld = 0; iss = 0; mul_pend = 0; dm_pend = 0;
      a_a = 0; a_d = 0; iss_a = 0;
      mul_a = 0; mul_d = 0; dm_a = 0; dm_d = 0;
   endtask

   task automatic model_edge();
      bit omv, odv;
      omv = m_mv;
      odv = m_dv;
      if (m_en) begin
         if (!m_busy[m_a] && !(iss && iss_a == m_a)) m_err = 1;
         m_busy[m_a] = 0;
      end
      if (iss) m_busy[iss_a] = 1;
      if (a_vld) begin
         m_en = 1; m_a = a_a; m_d = a_d;
      end else if (omv && (!odv || !m_rr_dm)) begin
         m_en = 1; m_a = hm_a; m_d = hm_d; m_mv = 0;
         if (odv) m_rr_dm = 1;
      end else if (odv) begin
         m_en = 1; m_a = hd_a; m_d = hd_d; m_dv = 0;
         if (omv) m_rr_dm = 0;
      end else begin
         m_en = 0;
      end
      if (mul_pend && !omv) begin
         m_mv = 1; hm_a = mul_a; hm_d = mul_d; mul_pend = 0;
      end
      if (dm_pend && !odv) begin
         m_dv = 1; hd_a = dm_a; hd_d = dm_d; dm_pend = 0;
      end
   endtask

   task automatic drive();
      bus.alu_xb_vld   = a_vld;
      bus.alu_xb_wrtA  = a_a;
      bus.alu_xb_d     = a_d;
      bus.mul_xb_vld   = mul_pend;
      bus.mul_xb_wrtA  = mul_a;
      bus.mul_xb_d     = mul_d;
      bus.dm_xb_vld    = dm_pend;
      bus.dm_xb_wrtA   = dm_a;
      bus.dm_xb_d      = dm_d;
      bus.ps_xb_issue  = iss;
      bus.ps_xb_issueA = iss_a;
   endtask

   task automatic compare_all(string tag);
      chk({tag, ".en"},   32'(bus.xb_rf_En),   32'(m_en));
      chk({tag, ".a"},    32'(bus.xb_rf_wrtA), 32'(m_a));
      chk({tag, ".d"},    32'(bus.xb_rf_d),    32'(m_d));
      chk({tag, ".busy"}, 32'(bus.xb_ps_busy), 32'(busy_vec()));
      chk({tag, ".err"},  32'(bus.xb_ps_err),  32'(m_err));
      chk({tag, ".mrdy"}, 32'(bus.xb_mul_rdy), 32'(!m_mv));
      chk({tag, ".drdy"}, 32'(bus.xb_dm_rdy),  32'(!m_dv));
   endtask

   task automatic step(string tag);
      drive();
      @(posedge clk);
      model_edge();
      #1;
      compare_all(tag);
      a_vld = 0;
      iss   = 0;
      drive();
   endtask

   task automatic do_reset();
      rst_n = 0;
      model_clear();
      drive();
      #1;
      compare_all("rst");
      @(posedge clk);
      #1;
      rst_n = 1;
   endtask

   task automatic issue(logic [3:0] r);
      iss = 1; iss_a = r;
      step("iss");
   endtask

   task automatic alu(logic [3:0] r, logic [15:0] d);
      a_vld = 1; a_a = r; a_d = d;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1;
      model_clear();
      drive();
      #2;
      do_reset();

      // ALU only
      issue(4'd3);
      alu(4'd3, 16'h1234);
      step("alu");
      chk("alu_en", 32'(bus.xb_rf_En), 32'd1);
      chk("alu_a", 32'(bus.xb_rf_wrtA), 32'd3);
      chk("alu_d", 32'(bus.xb_rf_d), 32'h1234);
      chk("alu_busy_set", 32'(bus.xb_ps_busy[3]), 32'd1);
      step("alu2");
      chk("alu_busy_clr", 32'(bus.xb_ps_busy[3]), 32'd0);
      chk("alu_err", 32'(bus.xb_ps_err), 32'd0);

      // contention
      do_reset();
      issue(4'd5);
      issue(4'd6);
      mul_pend = 1; mul_a = 4'd5; mul_d = 16'hAAAA;
      dm_pend  = 1; dm_a  = 4'd6; dm_d  = 16'h5555;
      step("ct0");
      chk("ct_mrdy0", 32'(bus.xb_mul_rdy), 32'd0);
      chk("ct_drdy0", 32'(bus.xb_dm_rdy), 32'd0);
      step("ct1");
      chk("ct_a1", 32'(bus.xb_rf_wrtA), 32'd5);
      chk("ct_d1", 32'(bus.xb_rf_d), 32'hAAAA);
      chk("ct_mrdy1", 32'(bus.xb_mul_rdy), 32'd1);
      chk("ct_drdy1", 32'(bus.xb_dm_rdy), 32'd0);
      step("ct2");
      chk("ct_a2", 32'(bus.xb_rf_wrtA), 32'd6);
      chk("ct_d2", 32'(bus.xb_rf_d), 32'h5555);
      chk("ct_drdy2", 32'(bus.xb_dm_rdy), 32'd1);

      // ALU priority
      do_reset();
      issue(4'd1); issue(4'd2); issue(4'd4); issue(4'd8);
      mul_pend = 1; mul_a = 4'd8; mul_d = 16'hBEEF;
      step("pr0");
      mul_pend = 1; mul_a = 4'd9; mul_d = 16'hCAFE;
      alu(4'd1, 16'h0001); step("pr1");
      chk("pr_a1", 32'(bus.xb_rf_wrtA), 32'd1);
      chk("pr_mrdy1", 32'(bus.xb_mul_rdy), 32'd0);
      alu(4'd2, 16'h0002); step("pr2");
      chk("pr_a2", 32'(bus.xb_rf_wrtA), 32'd2);
      chk("pr_mrdy2", 32'(bus.xb_mul_rdy), 32'd0);
      alu(4'd4, 16'h0004); step("pr3");
      chk("pr_a3", 32'(bus.xb_rf_wrtA), 32'd4);
      chk("pr_mrdy3", 32'(bus.xb_mul_rdy), 32'd0);
      step("pr4");
      chk("pr_a4", 32'(bus.xb_rf_wrtA), 32'd8);
      chk("pr_d4", 32'(bus.xb_rf_d), 32'hBEEF);
      step("pr5");
      step("pr6");

      // round-robin under repeated refill
      do_reset();
      order.delete();
      for (int i = 0; i < 12; i++) begin
         if (!mul_pend) begin mul_pend = 1; mul_a = 4'd1; mul_d = 16'(i); end
         if (!dm_pend)  begin dm_pend  = 1; dm_a  = 4'd2; dm_d  = 16'(i); end
         if (i % 2 == 1) alu(4'd3, 16'h0333);
         step("rr");
         if (bus.xb_rf_En && bus.xb_rf_wrtA != 4'd3)
            order.push_back(bus.xb_rf_wrtA);
      end
      chk("rr_cnt", 32'(order.size() >= 4), 32'd1);
      if (order.size() >= 4) begin
         chk("rr_g0", 32'(order[0]), 32'd1);
         chk("rr_g1", 32'(order[1]), 32'd2);
         chk("rr_g2", 32'(order[2]), 32'd1);
         chk("rr_g3", 32'(order[3]), 32'd2);
      end

      // scoreboard reuse
      do_reset();
      issue(4'd7);
      alu(4'd7, 16'h0777);
      step("ru0");
      issue(4'd7);
      chk("ru_busy", 32'(bus.xb_ps_busy[7]), 32'd1);
      chk("ru_err", 32'(bus.xb_ps_err), 32'd0);

      // error, then async reset with both entries full
      alu(4'd9, 16'h0999);
      step("er0");
      step("er1");
      chk("er_set", 32'(bus.xb_ps_err), 32'd1);
      step("er2");
      chk("er_sticky", 32'(bus.xb_ps_err), 32'd1);
      mul_pend = 1; mul_a = 4'd10; mul_d = 16'h1010;
      dm_pend  = 1; dm_a  = 4'd11; dm_d  = 16'h1111;
      alu(4'd12, 16'h0C0C); step("er3");
      alu(4'd13, 16'h0D0D); step("er4");
      chk("er_full_m", 32'(bus.xb_mul_rdy), 32'd0);
      chk("er_full_d", 32'(bus.xb_dm_rdy), 32'd0);
      #2;
      rst_n = 0;
      model_clear();
      drive();
      #1;
      chk("ar_en", 32'(bus.xb_rf_En), 32'd0);
      chk("ar_a", 32'(bus.xb_rf_wrtA), 32'd0);
      chk("ar_d", 32'(bus.xb_rf_d), 32'd0);
      chk("ar_busy", 32'(bus.xb_ps_busy), 32'd0);
      chk("ar_err", 32'(bus.xb_ps_err), 32'd0);
      chk("ar_mrdy", 32'(bus.xb_mul_rdy), 32'd1);
      chk("ar_drdy", 32'(bus.xb_dm_rdy), 32'd1);
      @(posedge clk);
      #1;
      rst_n = 1;
      for (int i = 0; i < 3; i++) begin
         step("ar_idle");
         chk("ar_nowr", 32'(bus.xb_rf_En), 32'd0);
      end

      // random traffic
      do_reset();
      for (int i = 0; i < 500; i++) begin
         if (!mul_pend && $urandom_range(0, 1) == 0) begin
            mul_pend = 1;
            mul_a = 4'($urandom);
            mul_d = 16'($urandom);
         end
         if (!dm_pend && $urandom_range(0, 1) == 0) begin
            dm_pend = 1;
            dm_a = 4'($urandom);
            dm_d = 16'($urandom);
         end
         if ($urandom_range(0, 2) == 0)
            alu(4'($urandom), 16'($urandom));
         if ($urandom_range(0, 1) == 0) begin
            iss = 1;
            iss_a = 4'($urandom);
         end
         step("rnd");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/cu_xb_wb.md
Name: cu_xb_wb

Overview:
Compute-unit write-back arbiter. It is the writer side of the register-file write port (data, address, enable). It merges results from the ALU, multiplier and data-memory load path onto the single register-file write port. It also keeps a destination scoreboard so the program sequencer can stall on registers that still have a result pending.

Parameters:
DATA_WIDTH, 16, width of result data and register-file write data
ADDRESS_WIDTH, 4, register address width; the register file has 2**ADDRESS_WIDTH entries

Ports:
clk  input  1  single clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
alu_xb_vld  input  1  ALU result valid; no backpressure, always accepted
alu_xb_wrtA  input  ADDRESS_WIDTH  ALU destination register
alu_xb_d  input  DATA_WIDTH  ALU result
mul_xb_vld  input  1  multiplier result valid
mul_xb_wrtA  input  ADDRESS_WIDTH  multiplier destination
mul_xb_d  input  DATA_WIDTH  multiplier result
xb_mul_rdy  output  1  multiplier holding register empty
dm_xb_vld  input  1  load data valid
dm_xb_wrtA  input  ADDRESS_WIDTH  load destination
dm_xb_d  input  DATA_WIDTH  load data
xb_dm_rdy  output  1  load holding register empty
ps_xb_issue  input  1  sequencer issued an instruction with a register destination
ps_xb_issueA  input  ADDRESS_WIDTH  destination reserved at issue
xb_rf_En  output  1  register-file write enable (registered)
xb_rf_wrtA  output  ADDRESS_WIDTH  register-file write address (registered)
xb_rf_d  output  DATA_WIDTH  register-file write data (registered)
xb_ps_busy  output  2**ADDRESS_WIDTH  scoreboard; bit n=1 means register n has a result pending
xb_ps_err  output  1  sticky: a write-back reached a register that was not busy

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: xb_rf_En=0, xb_rf_wrtA=0, xb_rf_d=0, xb_ps_busy=0, xb_ps_err=0.
  - Both holding registers are emptied, so xb_mul_rdy=1 and xb_dm_rdy=1.
  - Round-robin pointer is set to MUL.
  - Reset mid-operation discards held results without writing them.
- Holding registers: one entry each for MUL and DM.
  - rdy = entry empty; rdy is combinational from the valid flag.
  - A source loads its entry on vld&&rdy at a clock edge.
  - vld while rdy=0 is ignored; the source must hold its valid.
  - An entry frees at the edge where it is granted. rdy rises the following cycle, so there is no same-cycle refill.
- Arbitration, evaluated each cycle:
  - alu_xb_vld=1: the ALU wins unconditionally.
  - Otherwise, with only one entry full, that entry wins.
  - With both entries full, the entry under the rr pointer wins and rr flips to the other source. rr changes only on a contested grant.
  - With nothing pending, there is no grant.
- Output register: on a grant, next edge xb_rf_En=1 and xb_rf_wrtA/xb_rf_d take the winner's values. Otherwise xb_rf_En=0 and address/data hold their last values.
- Latency:
  - ALU: vld at cycle t gives xb_rf_En at t+1.
  - MUL/DM, uncontested: accepted at edge t gives write at t+2.
- Scoreboard:
  - Set bit ps_xb_issueA on ps_xb_issue at the edge.
  - Clear bit xb_rf_wrtA at the edge after xb_rf_En=1 is presented, i.e. when the register file captures.
  - If set and clear hit the same bit at the same edge, set wins (back-to-back reuse of a destination).
  - Different bits set/clear independently at the same edge.
- Error: xb_rf_En=1 with busy[xb_rf_wrtA]=0 and no same-edge set of that bit sets xb_ps_err. It clears only on reset.
- Starvation: sustained ALU traffic may starve MUL/DM indefinitely. The sequencer guarantees ALU gaps; no internal timeout.
- Width rules: data is passed unchanged with no arithmetic; address is used unmodified as the scoreboard index.

Test Plan:
- ALU only: issue R3; alu vld wrtA=3 d=16'h1234 at cycle 1 -> cycle 2 xb_rf_En=1, wrtA=3, d=1234; busy[3] 1 then 0 after edge; err=0.
- Contention: MUL (R5, 16'hAAAA) and DM (R6, 16'h5555) accepted at same edge, ALU idle -> MUL written first, DM next cycle; rdy of each returns the cycle after its grant.
- ALU priority: MUL entry full, ALU vld for 3 consecutive cycles (R1,R2,R4) -> three ALU writes, then MUL write on 4th cycle; xb_mul_rdy stays 0 throughout; no MUL accept while full.
- Round-robin: both entries refilled repeatedly for 4 contested grants -> grant order MUL, DM, MUL, DM.
- Scoreboard reuse: R7 busy, write-back of R7 presented while ps_xb_issue reissues R7 at the same edge -> busy[7] remains 1; err=0.
- Error and reset: ALU writes R9 never issued -> xb_ps_err=1 and sticky; then rst_n=0 asynchronously mid-cycle with both entries full -> all outputs 0 immediately, rdy=1, held data never written.
